serial_sub: RTL
===============

# serial_sub

Bit-serial unsigned subtractor that computes diff = a − b one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It sits directly upstream of the team's `full_sub` cell. It sequences operand bits and the borrow-in into that cell, and collects the sub/borrow-out it produces. It trades latency for area in datapaths where a WIDTH-bit ripple subtractor is too large.

## Interface
- `WIDTH`, default 8, operand/result width in bits; legal range 2..32.

- `clk`  input  1  rising-edge clock; the block uses only this clock.
- `rst`  input  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `start`  input  1  request a subtraction; acted on only in IDLE.
- `a`  input  WIDTH  minuend, unsigned; sampled in the cycle `start` is accepted.
- `b`  input  WIDTH  subtrahend, unsigned; sampled with `a`.
- `busy`  output  1  high while a subtraction is in progress.
- `done`  output  1  one-cycle pulse when `diff`/`borrow` update.
- `diff`  output  WIDTH  (a − b) mod 2^WIDTH, registered.
- `borrow`  output  1  final borrow-out; 1 iff a < b.

## Operation
- Datapath: operand shift registers `sa`, `sb` (shift right); borrow flop `br`; result shift register `sr` (shift in at MSB); bit counter `cnt` (width clog2(WIDTH)+1).
- Per-bit cell inputs: x = `sa[0]`, y = `sb[0]`, Bin = `br`.
  - sub = x ^ y ^ Bin.
  - Bout = (~x & y) | (y & Bin) | (~x & Bin).
  - The block instantiates `full_sub` for this logic.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - On `start` = 1: load `sa` ← a, `sb` ← b, `br` ← 0, `cnt` ← 0, then go to RUN.
    - Otherwise stay in IDLE.
  - RUN, each cycle:
    - `sr` ← {sub, `sr`[WIDTH-1:1]}, `br` ← Bout.
    - `sa`, `sb` shift right by 1; `cnt` ← `cnt` + 1.
    - When `cnt` = WIDTH−1 (last bit), go to DONE.
  - DONE, one cycle:
    - `diff` ← `sr`, `borrow` ← `br`, `done` = 1.
    - Return to IDLE.
- `start` in RUN or DONE is ignored and is not queued.
- `a`/`b` changes after the accept cycle have no effect.
- `diff`/`borrow` hold their last result until the next DONE. They do not change during RUN.
- Reset values: state IDLE, `busy` 0, `done` 0, `diff` 0, `borrow` 0; `sa`, `sb`, `sr`, `br`, `cnt` all 0.
- `rst` has priority over every other input, including `start` in the same cycle.
- A reset mid-RUN aborts the operation: no `done` pulse, and outputs return to their reset values.

## Timing
- Cycle T: `start` = 1 sampled in IDLE.
- Cycles T+1 .. T+WIDTH: RUN with `busy` = 1; bit i is processed in cycle T+1+i.
- Cycle T+WIDTH+1: DONE.
  - `done` = 1 and `busy` = 0.
  - `diff` and `borrow` show the new values from this cycle's edge (registered outputs, visible in the same cycle as `done`).
- Cycle T+WIDTH+2: IDLE; the earliest next accept.
- Latency from `start` to `done` is WIDTH+1 cycles. Sustained throughput is one result per WIDTH+2 cycles.
- `busy` is a registered state decode: high exactly in RUN.
- `done` is high exactly in DONE.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, one-cycle `start` → `busy` high 8 cycles, then `done` pulse; `diff`=0x37, `borrow`=0.
- a=0x10, b=0x20 → `diff`=0xF0, `borrow`=1. a=0x00, b=0xFF → `diff`=0x01, `borrow`=1. a=b=0x80 → `diff`=0x00, `borrow`=0.
- Random a/b, 1000 ops, back-to-back `start` held high → each `done` pulse is 10 cycles apart; `diff`/`borrow` match the reference model a−b and a<b.
- `start` pulsed while `busy`, and in the DONE cycle, with different a/b → ignored; the result equals the first operation; no extra `done`.
- Assert `rst` in the 3rd RUN cycle of a=0xFF, b=0x01 → next cycle IDLE; `busy`, `done`, `diff`, `borrow` all 0; no `done` follows. A subsequent op a=0x03, b=0x05 → `diff`=0xFE, `borrow`=1.
- WIDTH=2 build, exhaustive 16 operand pairs → every result is correct; latency is 3 cycles from `start` to `done`.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// Latency: WIDTH+1 cycles from accepted start to done; one result per WIDTH+2 cycles.
// Backpressure: none; start is taken only in IDLE, ignored (not queued) while busy or done.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset (priority over start)
//   start, a, b   request plus operands, sampled together in the IDLE accept cycle
//   busy          high exactly while bits are being processed (RUN)
//   done          one-cycle pulse, same cycle diff/borrow show the new result
//   diff, borrow  registered result (a - b) mod 2^WIDTH and final borrow (a < b)

// Single full-subtractor cell: x - y - bin.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic sub,
    output logic bout
);
    assign sub  = x ^ y ^ bin;
    assign bout = (~x & y) | (y & bin) | (~x & bin);
endmodule

module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             cell_sub;
    logic             cell_bout;
    logic             last_bit;
    logic [WIDTH-1:0] sr_nxt;

    full_sub u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (br),
        .sub  (cell_sub),
        .bout (cell_bout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign sr_nxt   = {cell_sub, sr[WIDTH-1:1]};

    // Outputs are pure decodes of the state register.
    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN:  if (last_bit) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= 1'b0;
                        cnt <= '0;
                    end
                end
                S_RUN: begin
                    sr  <= sr_nxt;
                    br  <= cell_bout;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + CW'(1);
                    // Publish on the edge that enters DONE so the new result is
                    // already visible in the cycle done is high. The last bit is
                    // still in flight here, hence sr_nxt / cell_bout rather than sr / br.
                    if (last_bit) begin
                        diff   <= sr_nxt;
                        borrow <= cell_bout;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
